// File: rtl/bridge_mmio_n_pkg.sv
// Shared types and defaults for the N-slot MMIO bridge.
// Holds the FSM state encoding, the default slot map and the wait-counter width.
package bridge_mmio_n_pkg;

    localparam int ADDR_W = 32;
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [4*ADDR_W-1:0] DEF_LSA = {
        32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000
    };
    localparam logic [4*ADDR_W-1:0] DEF_MSA = {
        32'h0000_7F23, 32'h0000_7F1B, 32'h0000_7F0B, 32'h0000_2FFF
    };

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bridge_mmio_n_decoder.sv
// Combinational N-way address range compare with priority encoding.
// On overlapping ranges the lowest slot index wins.
module bridge_mmio_n_decoder
    import bridge_mmio_n_pkg::*;
#(
    parameter int                        N_DEV = 4,
    parameter logic [N_DEV*ADDR_W-1:0]   LSA   = DEF_LSA,
    parameter logic [N_DEV*ADDR_W-1:0]   MSA   = DEF_MSA
) (
    input  logic [ADDR_W-1:0]          i_addr,
    output logic                       o_hit,
    output logic [slot_w(N_DEV)-1:0]   o_slot
);

    localparam int SW = slot_w(N_DEV);

    // Scan downwards so a lower-index hit overrides a higher one.
    always_comb begin
        o_hit  = 1'b0;
        o_slot = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((i_addr >= LSA[i*ADDR_W +: ADDR_W]) &&
                (i_addr <= MSA[i*ADDR_W +: ADDR_W])) begin
                o_hit  = 1'b1;
                o_slot = SW'(i);
            end
        end
    end

endmodule

// File: rtl/bridge_mmio_n.sv
// N-slot MMIO bridge: decode, register, strobe one device, wait, respond.
// Optional BRIDGE_ERR_CAPTURE_EN adds err_addr/err_cnt fault capture.
module bridge_mmio_n
    import bridge_mmio_n_pkg::*;
#(
    parameter int                        N_DEV = 4,
    parameter int                        DW    = 32,
    parameter logic [N_DEV*ADDR_W-1:0]   LSA   = DEF_LSA,
    parameter logic [N_DEV*ADDR_W-1:0]   MSA   = DEF_MSA,
    parameter logic [N_DEV*WAIT_W-1:0]   WAIT  = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req,
    input  logic                      pr_valid,
    input  logic [ADDR_W-1:0]         pr_addr,
    input  logic [DW-1:0]             pr_wd,
    input  logic [DW/8-1:0]           pr_we,
    output logic [DW-1:0]             pr_rd,
    output logic                      pr_ready,
    output logic                      pr_err,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic [DW-1:0]             dev_wd,
    output logic [N_DEV-1:0]          dev_sel,
    output logic [N_DEV*DW/8-1:0]     dev_we,
    input  logic [N_DEV*DW-1:0]       dev_rd
`ifdef BRIDGE_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0]         err_addr,
    output logic [7:0]                err_cnt
`endif
);

    localparam int BW = DW / 8;
    localparam int SW = slot_w(N_DEV);

    state_t                  r_state;
    logic [SW-1:0]           r_slot;
    logic [WAIT_W-1:0]       r_cnt;
    logic [ADDR_W-1:0]       r_addr;
    logic [DW-1:0]           r_wd;
    logic [DW-1:0]           r_rd;
    logic                    r_ready;
    logic                    r_err;
    logic [N_DEV-1:0]        r_sel;
    logic [N_DEV*BW-1:0]     r_we;

    logic                    w_hit;
    logic [SW-1:0]           w_slot;
    logic [BW-1:0]           w_we;
    logic [N_DEV-1:0]        w_sel_oh;
    logic [N_DEV*BW-1:0]     w_we_demux;
    logic [WAIT_W-1:0]       w_wait;
    logic [DW-1:0]           w_rd_mux;
    logic                    w_accept;

    bridge_mmio_n_decoder #(
        .N_DEV (N_DEV),
        .LSA   (LSA),
        .MSA   (MSA)
    ) u_dec (
        .i_addr (pr_addr),
        .o_hit  (w_hit),
        .o_slot (w_slot)
    );

    // An interrupt at accept turns a write into a plain read.
    assign w_we     = req ? '0 : pr_we;
    assign w_accept = (r_state == S_IDLE) && pr_valid;

    always_comb begin
        w_sel_oh   = '0;
        w_we_demux = '0;
        w_wait     = '0;
        w_rd_mux   = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (w_slot == SW'(i)) begin
                w_sel_oh[i]              = 1'b1;
                w_we_demux[i*BW +: BW]   = w_we;
                w_wait                   = WAIT[i*WAIT_W +: WAIT_W];
            end
            if (r_slot == SW'(i)) begin
                w_rd_mux = dev_rd[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_slot  <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wd    <= '0;
            r_rd    <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_sel   <= '0;
            r_we    <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (pr_valid) begin
                        r_addr <= pr_addr;
                        r_wd   <= pr_wd;
                        r_slot <= w_slot;
                        if (w_hit) begin
                            r_state <= S_ACCESS;
                            r_sel   <= w_sel_oh;
                            r_we    <= w_we_demux;
                            r_cnt   <= w_wait;
                        end else begin
                            r_state <= S_RESP;
                            r_ready <= 1'b1;
                            r_err   <= 1'b1;
                            r_rd    <= '0;
                        end
                    end
                end
                S_ACCESS, S_WAIT: begin
                    // Last device cycle: sample its read data for the response.
                    if (r_cnt == '0) begin
                        r_rd    <= w_rd_mux;
                        r_sel   <= '0;
                        r_ready <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pr_rd    = r_rd;
    assign pr_ready = r_ready;
    assign pr_err   = r_err;
    assign dev_addr = r_addr;
    assign dev_wd   = r_wd;
    assign dev_sel  = r_sel;
    assign dev_we   = r_we;

`ifdef BRIDGE_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] r_err_addr;
    logic [7:0]        r_err_cnt;
    logic              w_err_evt;

    assign w_err_evt = w_accept && !w_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_addr <= '0;
            r_err_cnt  <= '0;
        end else if (w_err_evt) begin
            r_err_addr <= pr_addr;
            if (r_err_cnt != 8'hFF) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err_addr = r_err_addr;
    assign err_cnt  = r_err_cnt;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_bridge_mmio_n.sv
// Scoreboard bench for bridge_mmio_n: random accesses vs. a slot-map model.
// Slots 1 and 2 overlap on 0x7F10..0x7F13 to exercise priority.
module tb_bridge_mmio_n;

    localparam int N = 4;
    localparam logic [127:0] P_LSA  = {32'h7F20, 32'h7F10, 32'h7F00, 32'h0000};
    localparam logic [127:0] P_MSA  = {32'h7F23, 32'h7F1B, 32'h7F13, 32'h2FFF};
    localparam logic [15:0]  P_WAIT = {4'd2, 4'd3, 4'd1, 4'd0};

    localparam int unsigned M_LO [N] = '{32'h0000, 32'h7F00, 32'h7F10, 32'h7F20};
    localparam int unsigned M_HI [N] = '{32'h2FFF, 32'h7F13, 32'h7F1B, 32'h7F23};
    localparam int          M_WT [N] = '{0, 1, 3, 2};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req = 1'b0;
    logic         pr_valid = 1'b0;
    logic [31:0]  pr_addr = '0;
    logic [31:0]  pr_wd = '0;
    logic [3:0]   pr_we = '0;
    logic [31:0]  pr_rd;
    logic         pr_ready;
    logic         pr_err;
    logic [31:0]  dev_addr;
    logic [31:0]  dev_wd;
    logic [3:0]   dev_sel;
    logic [15:0]  dev_we;
    logic [127:0] dev_rd = '0;
`ifdef BRIDGE_ERR_CAPTURE_EN
    logic [31:0]  err_addr;
    logic [7:0]   err_cnt;
`endif

    bridge_mmio_n #(
        .N_DEV (N),
        .DW    (32),
        .LSA   (P_LSA),
        .MSA   (P_MSA),
        .WAIT  (P_WAIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .pr_valid (pr_valid),
        .pr_addr  (pr_addr),
        .pr_wd    (pr_wd),
        .pr_we    (pr_we),
        .pr_rd    (pr_rd),
        .pr_ready (pr_ready),
        .pr_err   (pr_err),
        .dev_addr (dev_addr),
        .dev_wd   (dev_wd),
        .dev_sel  (dev_sel),
        .dev_we   (dev_we),
        .dev_rd   (dev_rd)
`ifdef BRIDGE_ERR_CAPTURE_EN
        ,
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        bit          err;
        int          lat;
        int          iss;
        int          slot;
        logic [31:0] addr;
        logic [31:0] wd;
    } exp_t;

    typedef struct {
        int          slot;
        logic [3:0]  we;
        int          cyc;
    } wexp_t;

    exp_t  eq[$];
    wexp_t wq[$];

    int checks = 0;
    int errors = 0;
    int sel_cycles = 0;
    int err_model = 0;

    function automatic int ref_slot(input logic [31:0] a);
        for (int i = 0; i < N; i++) begin
            if (a >= M_LO[i] && a <= M_HI[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] we_vec(input int s, input logic [3:0] we);
        logic [15:0] v;
        v = '0;
        v[s*4 +: 4] = we;
        return v;
    endfunction

    function automatic logic [3:0] sel_vec(input int s);
        logic [3:0] v;
        v = '0;
        if (s >= 0) v[s] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every DUT-visible event against the scoreboard.
    initial begin
        exp_t  e;
        wexp_t w;
        bit    miss;
        forever begin
            @(negedge clk or negedge reset);
            if (!reset) begin
                #1;
                chk("rst_ctrl", {pr_ready, pr_err, dev_sel, dev_we}, 0);
                chk("rst_pr_rd", pr_rd, 0);
                chk("rst_dev_addr", dev_addr, 0);
                chk("rst_dev_wd", dev_wd, 0);
`ifdef BRIDGE_ERR_CAPTURE_EN
                chk("rst_err_regs", {err_addr, err_cnt}, 0);
`endif
                eq.delete();
                wq.delete();
                sel_cycles = 0;
                err_model = 0;
            end else begin
                if (dev_we != '0) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write", dev_we, 0);
                    end else begin
                        w = wq.pop_front();
                        chk("dev_we", dev_we, we_vec(w.slot, w.we));
                        chk("write_cycle", cyc, w.cyc);
                    end
                end
                if (dev_sel != '0) begin
                    sel_cycles++;
                    if (eq.size() == 0) begin
                        chk("unexpected_sel", dev_sel, 0);
                    end else begin
                        chk("dev_sel", dev_sel,
                            eq[0].err ? 4'b0 : sel_vec(eq[0].slot));
                        chk("dev_addr", dev_addr, eq[0].addr);
                        chk("dev_wd", dev_wd, eq[0].wd);
                    end
                end
                if (!pr_ready) begin
                    chk("err_without_ready", pr_err, 0);
                end else if (eq.size() == 0) begin
                    chk("unexpected_ready", pr_ready, 0);
                end else begin
                    e = eq.pop_front();
                    chk("pr_err", pr_err, e.err);
                    chk("pr_rd", pr_rd, e.rd);
                    chk("latency", cyc - e.iss, e.lat);
                    chk("sel_cycles", sel_cycles, e.err ? 0 : e.lat - 1);
                    chk("sel_in_resp", dev_sel, 0);
                    miss = 1'b0;
                    if (wq.size() > 0) miss = (wq[0].cyc <= cyc);
                    chk("missing_write", miss, 0);
                    sel_cycles = 0;
`ifdef BRIDGE_ERR_CAPTURE_EN
                    if (e.err) begin
                        err_model = (err_model < 255) ? err_model + 1 : 255;
                        chk("err_addr", err_addr, e.addr);
                        chk("err_cnt", err_cnt, err_model);
                    end
`endif
                end
            end
        end
    end

    task automatic rand_dev();
        for (int i = 0; i < N; i++) dev_rd[i*32 +: 32] = $urandom();
    endtask

    // Present a request; b2b means it is driven during the previous RESP.
    task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] we, input bit rq, input bit b2b);
        exp_t e;
        int   s;
        int   ic;
        s  = ref_slot(a);
        ic = b2b ? cyc + 1 : cyc;
        e.addr = a;
        e.wd   = wd;
        e.iss  = ic;
        e.slot = s;
        e.err  = (s < 0);
        if (e.err) begin
            e.lat = 1;
            e.rd  = '0;
        end else begin
            e.lat = 2 + M_WT[s];
            e.rd  = dev_rd[s*32 +: 32];
            if (!rq && we != 0) wq.push_back('{s, we, ic + 1});
        end
        eq.push_back(e);
        pr_valid = 1'b1;
        pr_addr  = a;
        pr_wd    = wd;
        pr_we    = we;
        req      = rq;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n >= 2) req = $urandom_range(0, 1);
        end while (!pr_ready && n < 40);
        if (!pr_ready) begin
            $display("FAIL timeout: pr_ready 0 after %0d cycles, need 1", n);
            $fatal(1, "bounded wait expired");
        end
        #1;
    endtask

    task automatic go_idle(input int gap);
        pr_valid = 1'b0;
        repeat (gap + 1) @(negedge clk);
        #1;
    endtask

    task automatic access(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] we, input bit rq, input bit b2b);
        rand_dev();
        issue(a, wd, we, rq, b2b);
        wait_ready();
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] bnd [8];
        int k;
        int s;
        bnd = '{32'h0, 32'h2FFF, 32'h3000, 32'h7EFF,
                32'h7F00, 32'h7F13, 32'h7F23, 32'h7F24};
        k = $urandom_range(0, 5);
        if (k == 0) return bnd[$urandom_range(0, 7)];
        if (k == 1) return 32'($urandom_range(0, 32'h2FFF));
        if (k == 2) return 32'h7F00 + 32'($urandom_range(0, 32'h2F));
        if (k == 3) return $urandom();
        if (k == 4) return 32'h3000 + 32'($urandom_range(0, 32'h4EFF));
        s = $urandom_range(0, N - 1);
        return M_LO[s] + 32'($urandom_range(0, M_HI[s] - M_LO[s]));
    endfunction

    function automatic logic [31:0] pick_unmapped();
        if ($urandom_range(0, 1) == 0)
            return 32'h7F24 + 32'($urandom_range(0, 32'hFF));
        return 32'h3000 + 32'($urandom_range(0, 32'h4EFF));
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;

        rand_dev();
        dev_rd[31:0] = 32'hDEAD_BEEF;
        issue(32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
        wait_ready();

        go_idle(0);
        access(32'h7F14, 32'h5, 4'hF, 1'b0, 1'b0);
        go_idle(1);
        access(32'h0004, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
        go_idle(0);
        access(32'h7F30, 32'h0, 4'h3, 1'b0, 1'b0);
        access(32'h7F12, 32'hA5A5_0001, 4'h1, 1'b0, 1'b1);
        access(32'h7F10, 32'h0, 4'h0, 1'b0, 1'b1);
        access(32'h7F1B, 32'h0, 4'hC, 1'b0, 1'b1);
        access(32'h2FFF, 32'h0, 4'h0, 1'b0, 1'b1);
        access(32'h3000, 32'h0, 4'h0, 1'b0, 1'b1);
        access(32'h7F23, 32'h77, 4'h2, 1'b0, 1'b1);
        access(32'hFFFF_FFFF, 32'h0, 4'h0, 1'b0, 1'b1);

        go_idle(0);
        rand_dev();
        issue(32'h7F18, 32'hCAFE, 4'hF, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        pr_valid = 1'b0;
        req = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        access(32'h7F20, 32'h99, 4'hF, 1'b0, 1'b0);

        go_idle(0);
        for (int i = 0; i < 300; i++) begin
            access(pick_unmapped(), $urandom(), 4'($urandom_range(0, 15)),
                   1'b0, i > 0);
        end

        for (int i = 0; i < 400; i++) begin
            bit          b;
            logic [3:0]  we;
            b  = ($urandom_range(0, 1) == 1);
            we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (!b) go_idle($urandom_range(0, 2));
            access(pick_addr(), $urandom(), we, $urandom_range(0, 3) == 0, b);
        end

        go_idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
